// File: rtl/ser_pkg.sv
// Shared definitions for the operand bit serializer: FSM state encoding
// and the default operand width.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, LSB first, zero-filling from the MSB.
// Zero fill means a fully drained register presents 0 on q_lsb.
module piso_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_lsb
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  // Next contents: parallel load wins over shift.
  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = d;
    end else if (shift) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end else begin
      sh_d = sh_q;
    end
  end

  // Shift register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign q_lsb = sh_q[0];

endmodule

// File: rtl/operand_bit_serializer.sv
// Accepts a pair of WIDTH-bit operands over valid/ready and streams them
// LSB first, one bit pair per clock, with valid/first/last framing strobes.
module operand_bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             A_in,
  output logic             B_in,
  output logic             bit_valid,
  output logic             bit_first,
  output logic             bit_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic          ready_s;
  logic          accept_s;

  // Ready in IDLE, or on the last bit of a word so the next word follows gaplessly.
  always_comb begin
    ready_s  = 1'b0;
    accept_s = 1'b0;
    if (rst && ((state_q == IDLE) || (cnt_q == LAST_CNT))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end
    accept_s = in_valid && ready_s;
  end

  // Next-state, bit counter and framing strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept_s) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = SHIFT;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    first_d = accept_s;
    last_d  = (state_d == SHIFT) && (cnt_d == LAST_CNT);
  end

  // State, counter and strobe registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  // The edge leaving SHIFT shifts out the MSB, so IDLE presents zeros straight from the flops.
  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (state_q == SHIFT),
    .d     (a_word),
    .q_lsb (A_in)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept_s),
    .shift (state_q == SHIFT),
    .d     (b_word),
    .q_lsb (B_in)
  );

  assign in_ready  = ready_s;
  assign bit_valid = (state_q == SHIFT);
  assign bit_first = first_q;
  assign bit_last  = last_q;

endmodule

// File: tb/tb_operand_bit_serializer.sv
// Self-checking bench for operand_bit_serializer: table-driven words, a bit-pair
// scoreboard, and hand-written back-to-back, hold-off and mid-word reset sequences.
module tb_operand_bit_serializer;

  localparam int W = 8;

  typedef struct packed {
    logic a;
    logic b;
    logic first;
    logic last;
  } bit_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           gap;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a_word = '0;
  logic [W-1:0] b_word = '0;
  logic         in_ready;
  logic         A_in;
  logic         B_in;
  logic         bit_valid;
  logic         bit_first;
  logic         bit_last;

  bit_t         exp_q[$];
  vec_t         vecs[5];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] cap_a, cap_b;
  int           n_first, n_last, run_len, max_run;

  operand_bit_serializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_word    (a_word),
    .b_word    (b_word),
    .A_in      (A_in),
    .B_in      (B_in),
    .bit_valid (bit_valid),
    .bit_first (bit_first),
    .bit_last  (bit_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] a, input logic [W-1:0] b);
    bit_t e;
    for (int i = 0; i < W; i++) begin
      e.a     = a[i];
      e.b     = b[i];
      e.first = (i == 0);
      e.last  = (i == W - 1);
      exp_q.push_back(e);
    end
  endtask

  // Compare the outputs presented after an edge against the scoreboard.
  task automatic check_outputs();
    bit_t e;
    if (bit_valid) begin
      run_len++;
      if (exp_q.size() == 0) begin
        check("unexpected_bit", 32'(bit_valid), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("bit_pair", 32'({A_in, B_in, bit_first, bit_last}), 32'(e));
      end
      cap_a   = {A_in, cap_a[W-1:1]};
      cap_b   = {B_in, cap_b[W-1:1]};
      n_first = n_first + int'(bit_first);
      n_last  = n_last + int'(bit_last);
    end else begin
      if (run_len > max_run) max_run = run_len;
      run_len = 0;
      check("idle_zero", 32'({A_in, B_in, bit_first, bit_last}), 32'(0));
      if (exp_q.size() != 0) check("gap_in_stream", 32'(bit_valid), 32'(1));
    end
  endtask

  // One clock: inputs were driven at the negedge; predict ready/accept, then check after the edge.
  task automatic cycle();
    logic exp_ready;
    #1;
    exp_ready = rst && (exp_q.size() == 0);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    if (rst && in_valid && exp_ready) push_word(a_word, b_word);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic clear_stats();
    cap_a   = '0;
    cap_b   = '0;
    n_first = 0;
    n_last  = 0;
    max_run = 0;
  endtask

  task automatic run_word(input vec_t v);
    clear_stats();
    a_word   = v.a;
    b_word   = v.b;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (W - 1 + v.gap) cycle();
    check("word_a", 32'(cap_a), 32'(v.exp_a));
    check("word_b", 32'(cap_b), 32'(v.exp_b));
    check("word_first_cnt", 32'(n_first), 32'(1));
    check("word_last_cnt", 32'(n_last), 32'(1));
    check("word_run_len", 32'(max_run), 32'(W));
  endtask

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'h3C, gap: 1, exp_a: 8'hA5, exp_b: 8'h3C};
    vecs[1] = '{a: 8'h00, b: 8'hFF, gap: 5, exp_a: 8'h00, exp_b: 8'hFF};
    vecs[2] = '{a: 8'h80, b: 8'h01, gap: 1, exp_a: 8'h80, exp_b: 8'h01};
    vecs[3] = '{a: 8'h5A, b: 8'hC3, gap: 2, exp_a: 8'h5A, exp_b: 8'hC3};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, gap: 1, exp_a: 8'hFF, exp_b: 8'hFF};
    run_len = 0;
    clear_stats();

    // Reset held for 3 cycles with in_valid toggling.
    #2 rst = 1'b0;
    @(negedge clk);
    a_word = 8'h12;
    b_word = 8'h34;
    repeat (3) begin
      in_valid = ~in_valid;
      cycle();
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    cycle();

    // Table-driven single words; the first is A5/3C, the gap-5 entry covers idle zeros.
    for (int i = 0; i < 5; i++) run_word(vecs[i]);

    // Back-to-back: second pair presented on the bit_last cycle.
    clear_stats();
    a_word   = 8'hA5;
    b_word   = 8'h3C;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (W - 1) cycle();
    check("b2b_last_seen", 32'(bit_last), 32'(1));
    a_word   = 8'hFF;
    b_word   = 8'h01;
    in_valid = 1'b1;
    cycle();
    check("b2b_first_follows", 32'({bit_valid, bit_first}), 32'(2'b11));
    in_valid = 1'b0;
    repeat (W - 1) cycle();
    repeat (2) cycle();
    check("b2b_run_len", 32'(max_run), 32'(2 * W));
    check("b2b_first_cnt", 32'(n_first), 32'(2));
    check("b2b_word2", 32'({cap_a, cap_b}), 32'({8'hFF, 8'h01}));

    // in_valid held from cnt=3: no capture until cnt=7.
    clear_stats();
    a_word   = 8'hC3;
    b_word   = 8'h5A;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (3) cycle();
    a_word   = 8'h00;
    b_word   = 8'hFF;
    in_valid = 1'b1;
    repeat (4) cycle();
    check("hold_word1", 32'({cap_a, cap_b}), 32'({8'hC3, 8'h5A}));
    cycle();
    in_valid = 1'b0;
    repeat (W - 1) cycle();
    cycle();
    check("hold_word2", 32'({cap_a, cap_b}), 32'({8'h00, 8'hFF}));
    check("hold_first_cnt", 32'(n_first), 32'(2));

    // Reset asserted at cnt=4: outputs clear immediately, new word restarts at bit 0.
    clear_stats();
    a_word   = 8'h96;
    b_word   = 8'h69;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    check("pre_rst_valid", 32'(bit_valid), 32'(1));
    rst = 1'b0;
    #1;
    check("rst_async_out", 32'({bit_valid, A_in, B_in, bit_first, bit_last}), 32'(0));
    check("rst_async_ready", 32'(in_ready), 32'(0));
    exp_q.delete();
    cycle();
    rst = 1'b1;
    run_word('{a: 8'hE7, b: 8'h18, gap: 1, exp_a: 8'hE7, exp_b: 8'h18});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
